// File: rtl/audio_adc_capture.sv
// audio_adc_capture: I2S receive path for the WM8731 ADC link.
// Oversamples the codec-mastered BCLK/ADCLRCK/ADCDAT on clk, deserialises
// MSB-first left/right words and queues complete stereo pairs in a small FIFO
// that is drained through a valid/ready interface.
module audio_adc_capture #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  AUD_BCLK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PAIR_W = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  // Input synchronisers and edge-detect history
  logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   bclk_prev_q, bclk_prev_d;
  logic                   lrck_last_q, lrck_last_d;
  logic                   bclk_s, lrck_s, dat_s;
  logic                   bclk_rise_s, lr_edge_s;

  // Slot receiver state
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic                   chan_q, chan_d;
  logic [DATA_WIDTH-1:0]  left_hold_q, left_hold_d;
  logic                   have_left_q, have_left_d;
  logic                   commit_s;
  logic [DATA_WIDTH-1:0]  commit_word_s;
  logic                   push_s;
  logic [PAIR_W-1:0]      push_pair_s;

  // Pair FIFO with a registered head
  logic [PAIR_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PAIR_W-1:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [OCC_W-1:0]       remain_s;
  logic [PAIR_W-1:0]      head_q, head_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overflow_q, overflow_d;
  logic                   pop_s, full_s, accept_s, drop_s;

  // Synchroniser shift, BCLK rise detect and LRCK history sampled on BCLK rises
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], AUD_BCLK};
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], AUD_ADCLRCK};
    dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], AUD_ADCDAT};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lrck_s      = lrck_sync_q[SYNC_STAGES-1];
    dat_s       = dat_sync_q[SYNC_STAGES-1];
    bclk_prev_d = bclk_s;
    bclk_rise_s = bclk_s & ~bclk_prev_q;
    lr_edge_s   = bclk_rise_s & (lrck_s ^ lrck_last_q);
    if (bclk_rise_s) begin
      lrck_last_d = lrck_s;
    end else begin
      lrck_last_d = lrck_last_q;
    end
  end

  // Slot receiver: next state, shifting, word commit and pair assembly.
  // The BCLK rise that reveals an LRCK change carries the I2S delay bit, so
  // SKIP only clears the counter and the following rise delivers the MSB.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    chan_d        = chan_q;
    left_hold_d   = left_hold_q;
    have_left_d   = have_left_q;
    commit_s      = 1'b0;
    commit_word_s = '0;
    push_s        = 1'b0;
    push_pair_s   = '0;
    if (!enable) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      have_left_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          have_left_d = 1'b0;
          if (lr_edge_s && !lrck_s) begin
            chan_d  = 1'b0;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SKIP: begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (lr_edge_s) begin
            // short slot: left-align the bits received, LSBs become zero
            commit_s      = 1'b1;
            commit_word_s = shreg_q << (CNT_W'(DATA_WIDTH) - cnt_q);
            chan_d        = lrck_s;
            state_d       = ST_SKIP;
          end else if (bclk_rise_s) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], dat_s};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
              commit_s      = 1'b1;
              commit_word_s = {shreg_q[DATA_WIDTH-2:0], dat_s};
              state_d       = ST_HOLD;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (lr_edge_s) begin
            chan_d  = lrck_s;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
      if (commit_s && !chan_q) begin
        left_hold_d = commit_word_s;
        have_left_d = 1'b1;
      end else if (commit_s && have_left_q) begin
        push_s      = 1'b1;
        push_pair_s = {left_hold_q, commit_word_s};
      end else begin
        push_s = 1'b0;
      end
    end
  end

  // FIFO bookkeeping, head register update and sticky overflow
  always_comb begin
    pop_s    = out_valid_q & out_ready;
    full_s   = (occ_q == OCC_W'(FIFO_DEPTH));
    accept_s = push_s & (~full_s | pop_s);
    drop_s   = push_s & full_s & ~pop_s;
    mem_d    = mem_q;
    if (accept_s) begin
      mem_d[wr_ptr_q] = push_pair_s;
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(accept_s);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    occ_d    = occ_q + OCC_W'(accept_s) - OCC_W'(pop_s);
    remain_s = occ_q - OCC_W'(pop_s);
    if (remain_s != '0) begin
      head_d      = mem_q[rd_ptr_d];
      out_valid_d = 1'b1;
    end else if (accept_s) begin
      head_d      = push_pair_s;
      out_valid_d = 1'b1;
    end else begin
      head_d      = head_q;
      out_valid_d = 1'b0;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // State registers for synchronisers, receiver and FIFO
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_last_q <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      chan_q      <= 1'b0;
      left_hold_q <= '0;
      have_left_q <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_q      <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      bclk_sync_q <= bclk_sync_d;
      lrck_sync_q <= lrck_sync_d;
      dat_sync_q  <= dat_sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_last_q <= lrck_last_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      chan_q      <= chan_d;
      left_hold_q <= left_hold_d;
      have_left_q <= have_left_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      head_q      <= head_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_left  = head_q[PAIR_W-1:DATA_WIDTH];
  assign out_right = head_q[DATA_WIDTH-1:0];
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_audio_adc_capture.sv
// Testbench for audio_adc_capture: I2S bus-functional model, scoreboard queue
// of expected stereo pairs and directed scenarios with random sample data.
module tb_audio_adc_capture;

  localparam int DEPTH      = 4;
  localparam int ACT_NONE   = 0;
  localparam int ACT_PUSH   = 1;
  localparam int ACT_RST    = 2;
  localparam int ACT_EN_OFF = 3;
  localparam int ACT_EN_ON  = 4;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic        AUD_BCLK;
  logic        AUD_ADCLRCK;
  logic        AUD_ADCDAT;
  logic [23:0] out_left;
  logic [23:0] out_right;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clear_overflow;

  int          total;
  int          bad;
  int          pops;
  int          valid_cycles;
  logic [47:0] mq[$];
  logic        exp_ovf;
  logic [47:0] pend;
  bit          pulse_ready;
  bit          hold_chk;
  logic [47:0] held;
  int          p0;
  int          v0;
  logic [23:0] lw;

  audio_adc_capture dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .AUD_BCLK       (AUD_BCLK),
    .AUD_ADCLRCK    (AUD_ADCLRCK),
    .AUD_ADCDAT     (AUD_ADCDAT),
    .out_left       (out_left),
    .out_right      (out_right),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // word the receiver should commit for a slot carrying the top n bits of w
  function automatic logic [23:0] model_word(input logic [23:0] w, input int n);
    logic [23:0] m;
    m = 24'hFFFFFF;
    if (n < 24) m = m << (24 - n);
    return w & m;
  endfunction

  task automatic model_push(input logic [47:0] p);
    if (mq.size() < DEPTH) mq.push_back(p);
    else exp_ovf = 1'b1;
  endtask

  // one I2S slot: rise 0 is the delay bit, rises 1..nbits carry w MSB first;
  // LRCK/DAT change with BCLK low, BCLK period = 16 clk
  task automatic send_slot(input logic lr, input logic [23:0] w, input int nbits,
                           input int nrises, input int act_at, input int act);
    for (int i = 0; i < nrises; i++) begin
      logic d;
      d = 1'b0;
      if (i >= 1 && i <= nbits) d = w[24 - i];
      @(negedge clk);
      AUD_BCLK = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT = d;
      if (i == act_at && act == ACT_EN_OFF) enable = 1'b0;
      if (i == act_at && act == ACT_EN_ON) enable = 1'b1;
      repeat (8) @(negedge clk);
      AUD_BCLK = 1'b1;
      repeat (2) @(negedge clk);
      if (i == act_at && act == ACT_PUSH && pulse_ready) out_ready = 1'b1;
      @(negedge clk);
      if (i == act_at && act == ACT_PUSH) begin
        if (pulse_ready) out_ready = 1'b0;
        model_push(pend);
      end
      if (i == act_at && act == ACT_RST) resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  // full frame: left slot (possibly short) followed by a 32-bit right slot
  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int lbits);
    pend = {model_word(l, lbits), r};
    send_slot(1'b0, l, lbits, (lbits < 24) ? lbits + 1 : 32, -1, ACT_NONE);
    send_slot(1'b1, r, 24, 32, 24, ACT_PUSH);
  endtask

  // output monitor: scoreboard on pops, head stability while stalled
  initial begin
    hold_chk = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (resetn) begin
        if (hold_chk) check("hold_stable", 64'({out_valid, out_left, out_right}), 64'({1'b1, held}));
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) begin
          check("pop_expected", 64'(mq.size() != 0), 64'd1);
          if (mq.size() != 0) begin
            check("pop_data", 64'({out_left, out_right}), 64'(mq[0]));
            void'(mq.pop_front());
          end
          pops++;
        end
        hold_chk = out_valid && !out_ready;
        held = {out_left, out_right};
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    total = 0; bad = 0; pops = 0; valid_cycles = 0;
    resetn = 1'b0; enable = 1'b1; AUD_BCLK = 1'b0; AUD_ADCLRCK = 1'b0; AUD_ADCDAT = 1'b0;
    out_ready = 1'b0; clear_overflow = 1'b0; pulse_ready = 1'b0; exp_ovf = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_left", 64'(out_left), 64'd0);
    check("rst_right", 64'(out_right), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    resetn = 1'b1;

    // 6: start mid left slot, then reset pulse mid right slot
    send_slot(1'b0, 24'($urandom), 12, 12, -1, ACT_NONE);
    send_slot(1'b1, 24'($urandom), 24, 32, -1, ACT_NONE);
    send_slot(1'b0, 24'($urandom), 24, 32, -1, ACT_NONE);
    send_slot(1'b1, 24'($urandom), 24, 32, 10, ACT_RST);
    repeat (4) @(negedge clk);
    check("t6_pops", 64'(pops), 64'd0);
    check("t6_outputs", 64'({out_valid, overflow, out_left, out_right}), 64'd0);

    // 1: single known pair, consumer always ready
    out_ready = 1'b1;
    p0 = pops; v0 = valid_cycles;
    send_frame(24'h123456, 24'hABCDEF, 24);
    repeat (8) @(negedge clk);
    check("t1_pops", 64'(pops - p0), 64'd1);
    check("t1_valid_cycles", 64'(valid_cycles - v0), 64'd1);
    check("t1_last_pair", 64'({out_left, out_right}), 64'h123456ABCDEF);
    check("t1_sb_empty", 64'(mq.size()), 64'd0);

    // 4: short left slot of 16 bits
    p0 = pops;
    lw = {16'hA5A5, 8'($urandom)};
    send_frame(lw, 24'($urandom), 16);
    repeat (8) @(negedge clk);
    check("t4_pops", 64'(pops - p0), 64'd1);
    check("t4_left_zero_fill", 64'(out_left), 64'hA5A500);

    // 5: disable after 10 left bits, re-enable mid right slot
    p0 = pops;
    send_slot(1'b0, 24'($urandom), 24, 32, 11, ACT_EN_OFF);
    send_slot(1'b1, 24'($urandom), 24, 32, 12, ACT_EN_ON);
    repeat (8) @(negedge clk);
    check("t5_no_pair", 64'({out_valid, 32'(pops - p0)}), 64'd0);
    send_frame(24'($urandom), 24'($urandom), 24);
    repeat (8) @(negedge clk);
    check("t5_next_frame", 64'(pops - p0), 64'd1);

    // 2: stalled consumer, five pairs, fifth dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(24'(k), 24'($urandom), 24);
    repeat (4) @(negedge clk);
    check("t2_ovf_set", 64'(overflow), 64'(exp_ovf));
    check("t2_head", 64'({out_valid, out_left}), 64'({1'b1, mq[0][47:24]}));
    p0 = pops;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_drain_pops", 64'(pops - p0), 64'd4);
    check("t2_hold_last", 64'({out_valid, out_left}), 64'({1'b0, 24'd4}));
    check("t2_sb_empty", 64'(mq.size()), 64'd0);
    check("t2_ovf_sticky", 64'(overflow), 64'd1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_ovf_cleared", 64'(overflow), 64'(exp_ovf));

    // 3: full FIFO, pop coincides with the completing pair
    for (int k = 0; k < 4; k++) send_frame(24'($urandom), 24'($urandom), 24);
    p0 = pops;
    pulse_ready = 1'b1;
    send_frame(24'($urandom), 24'($urandom), 24);
    pulse_ready = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_ovf_clear", 64'(overflow), 64'(exp_ovf));
    check("t3_one_pop", 64'(pops - p0), 64'd1);
    check("t3_head", 64'({out_valid, out_left, out_right}), 64'({1'b1, mq[0]}));
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_drain_pops", 64'(pops - p0), 64'd5);
    check("t3_empty", 64'({out_valid, 32'(mq.size())}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
